mac_27x27_pipe: RTL and testbench
=================================

Name: mac_27x27_pipe

Overview:
Behavioural model of a hard-DSP 27x27 multiplier block in m27x27 mode: result = ax * ay. It has up to four optional, individually enabled pipeline stages: input, input-pipeline, second-pipeline and output. Portable RTL wrappers use it as a drop-in stand-in for vendor DSP primitives, and simulation uses it as a golden model. It targets fixed-latency multiply paths in arithmetic datapaths.

Parameters:
- AX_WIDTH, 27: width of operand ax; legal range 1..27.
- AY_WIDTH, 27: width of operand ay; legal range 1..27.
- RESULT_A_WIDTH, 54: width of resulta; legal range 1..64.
- AX_SIGNED, 0: 1 = ax is two's complement; 0 = unsigned.
- AY_SIGNED, 0: 1 = ay is two's complement; 0 = unsigned.
- INPUT_REG, 1: 1 = register ax/ay (stage 1).
- INPUT_PIPELINE_REG, 0: 1 = pipeline register after the input stage (stage 2).
- SECOND_PIPELINE_REG, 0: 1 = register on the product (stage 3).
- OUTPUT_REG, 1: 1 = register on resulta (stage 4).

Ports:
- clk, input, 1: single clock; all registers update on the rising edge.
- clr_n, input, 1: asynchronous, active-low reset for all stages.
- ena, input, 3: per-stage clock enables, active high. ena[0] = stage 1; ena[1] = stages 2 and 3; ena[2] = stage 4.
- ax, input, AX_WIDTH: multiplicand.
- ay, input, AY_WIDTH: multiplier.
- resulta, output, RESULT_A_WIDTH: product.

Behaviour:
- Operand extension: each operand is extended to 27 bits. Sign-extend if its *_SIGNED parameter is 1; otherwise zero-extend.
- Product: a full 54-bit product is formed with signed arithmetic when either operand is signed; otherwise unsigned.
- Result width:
  - If RESULT_A_WIDTH < 54, resulta is the low RESULT_A_WIDTH bits of the product.
  - If RESULT_A_WIDTH > 54, the product is extended: sign-extended if signed arithmetic is in use, otherwise zero-extended.
- Stage order: ax/ay -> stage1 -> stage2 -> multiply -> stage3 -> stage4 -> resulta.
- Stage 2 holds the operands. Stage 3 holds the product.
- A disabled stage (parameter 0) is a wire.
- Latency = INPUT_REG + INPUT_PIPELINE_REG + SECOND_PIPELINE_REG + OUTPUT_REG clock cycles, range 0..4. With latency 0 the block is purely combinational.
- Enable behaviour: an enabled stage whose ena bit is 0 holds its value. Downstream stages whose ena is 1 keep advancing, so resulta may repeat or skip values. No bubble tracking is done.
- Reset:
  - While clr_n = 0, every present register is asynchronously 0.
  - resulta = 0 immediately whenever OUTPUT_REG = 1.
  - With OUTPUT_REG = 0, resulta is the combinational product of the cleared upstream register contents, i.e. 0 when any operand stage exists.
- Reset release: registers load on the first rising clk edge after clr_n goes high (subject to ena).
- Reset mid-operation flushes all in-flight products. Correct results reappear exactly "latency" enabled cycles after new inputs are applied.
- Simultaneous edge and reset: reset dominates.
- Parameter checks: out-of-range widths terminate elaboration with $fatal and a message naming the parameter.
- No overflow, saturation or rounding logic.

Test Plan:
- Default parameters (latency 2), unsigned, ena = 3'b111: ax = 0x7FFFFFF, ay = 0x7FFFFFF -> resulta = 0x3FFFFFF0000001 on the 2nd rising edge after application. Then ax = 3, ay = 5 -> resulta = 15 two cycles later.
- Latency sweep with all four stages on (latency 4): stream ax = i, ay = i+1 for i = 0..9 each cycle -> resulta = (i-4)*(i-3) products, appearing exactly 4 cycles after each input pair.
- Signed: AX_SIGNED = AY_SIGNED = 1, ax = ay = 0x7FFFFFF (-1) -> resulta = 1. Then ax = -2, ay = 3 -> resulta = 54-bit two's complement of 6 (0x3FFFFFFFFFFFFA).
- Enable stall at latency 2: hold ena[0] = 0 for 3 cycles while ax/ay change -> resulta keeps the product of the operands captured before the stall. Restore ena -> new products resume after 2 cycles.
- Reset mid-stream: assert clr_n = 0 asynchronously between clock edges -> resulta = 0 immediately. Deassert and apply ax = 1000, ay = 1000 -> resulta = 1000000 after the configured latency.
- Truncation: RESULT_A_WIDTH = 16, ax = 0x1234, ay = 0x100 -> resulta = 0x3400.

Source files
------------

// File: rtl/mac_27x27_pipe.sv
// 27x27 multiplier in m27x27 mode: resulta = ax * ay, with four optional
// pipeline stages (input, input-pipeline, product, output).
module mac_27x27_pipe #(
    parameter int AX_WIDTH            = 27,
    parameter int AY_WIDTH            = 27,
    parameter int RESULT_A_WIDTH      = 54,
    parameter bit AX_SIGNED           = 1'b0,
    parameter bit AY_SIGNED           = 1'b0,
    parameter bit INPUT_REG           = 1'b1,
    parameter bit INPUT_PIPELINE_REG  = 1'b0,
    parameter bit SECOND_PIPELINE_REG = 1'b0,
    parameter bit OUTPUT_REG          = 1'b1
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic [2:0]                ena,
    input  logic [AX_WIDTH-1:0]       ax,
    input  logic [AY_WIDTH-1:0]       ay,
    output logic [RESULT_A_WIDTH-1:0] resulta
);

    localparam bit USE_SIGNED = AX_SIGNED | AY_SIGNED;

    if (AX_WIDTH < 1 || AX_WIDTH > 27) begin : g_bad_ax
        $fatal(1, "mac_27x27_pipe: AX_WIDTH out of range 1..27");
    end
    if (AY_WIDTH < 1 || AY_WIDTH > 27) begin : g_bad_ay
        $fatal(1, "mac_27x27_pipe: AY_WIDTH out of range 1..27");
    end
    if (RESULT_A_WIDTH < 1 || RESULT_A_WIDTH > 64) begin : g_bad_res
        $fatal(1, "mac_27x27_pipe: RESULT_A_WIDTH out of range 1..64");
    end

    logic [26:0] ax_ext, ay_ext;
    logic [26:0] s1_ax, s1_ay;
    logic [26:0] s2_ax, s2_ay;
    logic [53:0] prod, s3_prod;
    logic [RESULT_A_WIDTH-1:0] res_next;

    always_comb begin
        ax_ext = AX_SIGNED ? 27'($signed(ax)) : 27'(ax);
        ay_ext = AY_SIGNED ? 27'($signed(ay)) : 27'(ay);
    end

    if (INPUT_REG) begin : g_s1
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                s1_ax <= '0;
                s1_ay <= '0;
            end else if (ena[0]) begin
                s1_ax <= ax_ext;
                s1_ay <= ay_ext;
            end
        end
    end else begin : g_s1_wire
        assign s1_ax = ax_ext;
        assign s1_ay = ay_ext;
    end

    if (INPUT_PIPELINE_REG) begin : g_s2
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                s2_ax <= '0;
                s2_ay <= '0;
            end else if (ena[1]) begin
                s2_ax <= s1_ax;
                s2_ay <= s1_ay;
            end
        end
    end else begin : g_s2_wire
        assign s2_ax = s1_ax;
        assign s2_ay = s1_ay;
    end

    // One signed operand makes the whole multiply signed, as in the hard block.
    if (USE_SIGNED) begin : g_mul_s
        assign prod = $signed(s2_ax) * $signed(s2_ay);
    end else begin : g_mul_u
        assign prod = 54'(s2_ax) * 54'(s2_ay);
    end

    if (SECOND_PIPELINE_REG) begin : g_s3
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n)
                s3_prod <= '0;
            else if (ena[1])
                s3_prod <= prod;
        end
    end else begin : g_s3_wire
        assign s3_prod = prod;
    end

    if (RESULT_A_WIDTH <= 54) begin : g_trunc
        assign res_next = s3_prod[RESULT_A_WIDTH-1:0];
    end else begin : g_ext
        assign res_next = {{(RESULT_A_WIDTH-54){USE_SIGNED & s3_prod[53]}}, s3_prod};
    end

    if (OUTPUT_REG) begin : g_s4
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n)
                resulta <= '0;
            else if (ena[2])
                resulta <= res_next;
        end
    end else begin : g_s4_wire
        assign resulta = res_next;
    end

    // Enable bits and upper product bits are unused in some configurations.
    logic unused_bits;
    assign unused_bits = ^{ena, s3_prod};

endmodule

// File: tb/tb_mac_27x27_pipe.sv
// Directed bench for mac_27x27_pipe: several parameterisations share one
// stimulus; expected values are hand-computed constants.
module tb_mac_27x27_pipe;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [2:0]  ena;
    logic [26:0] ax, ay;
    logic [53:0] res_def, res_lat4, res_sgn;
    logic [15:0] res_trunc;
    logic [63:0] res_comb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_27x27_pipe u_def (
        .clk(clk), .clr_n(clr_n), .ena(ena), .ax(ax), .ay(ay), .resulta(res_def)
    );

    mac_27x27_pipe #(
        .INPUT_PIPELINE_REG(1'b1), .SECOND_PIPELINE_REG(1'b1)
    ) u_lat4 (
        .clk(clk), .clr_n(clr_n), .ena(ena), .ax(ax), .ay(ay), .resulta(res_lat4)
    );

    mac_27x27_pipe #(
        .AX_SIGNED(1'b1), .AY_SIGNED(1'b1)
    ) u_sgn (
        .clk(clk), .clr_n(clr_n), .ena(ena), .ax(ax), .ay(ay), .resulta(res_sgn)
    );

    mac_27x27_pipe #(
        .RESULT_A_WIDTH(16)
    ) u_trunc (
        .clk(clk), .clr_n(clr_n), .ena(ena), .ax(ax), .ay(ay), .resulta(res_trunc)
    );

    mac_27x27_pipe #(
        .RESULT_A_WIDTH(64), .AX_SIGNED(1'b1), .AY_SIGNED(1'b1),
        .INPUT_REG(1'b0), .OUTPUT_REG(1'b0)
    ) u_comb (
        .clk(clk), .clr_n(clr_n), .ena(ena), .ax(ax), .ay(ay), .resulta(res_comb)
    );

    typedef struct {
        logic [26:0] ax;
        logic [26:0] ay;
        logic [53:0] e_u;
        logic [53:0] e_s;
        logic [15:0] e_t;
        logic [63:0] e_c;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{27'h7FFFFFF, 27'h7FFFFFF, 54'h3FFFFFF0000001, 54'h1, 16'h0001, 64'h1};
        vecs[1] = '{27'd3, 27'd5, 54'd15, 54'd15, 16'd15, 64'd15};
        vecs[2] = '{27'h7FFFFFE, 27'd3, 54'h17FFFFFA, 54'h3FFFFFFFFFFFFA, 16'hFFFA,
                    64'hFFFFFFFFFFFFFFFA};
        vecs[3] = '{27'h1234, 27'h100, 54'h123400, 54'h123400, 16'h3400, 64'h123400};
        vecs[4] = '{27'd1000, 27'd1000, 54'd1000000, 54'd1000000, 16'h4240, 64'd1000000};
        vecs[5] = '{27'h4000000, 27'd2, 54'h8000000, 54'h3FFFFFF8000000, 16'h0000,
                    64'hFFFFFFFFF8000000};
        vecs[6] = '{27'd0, 27'h7FFFFFF, 54'd0, 54'd0, 16'd0, 64'd0};

        // Reset state: registered outputs cleared, combinational instance live
        clr_n = 1'b0;
        ena   = 3'b111;
        ax    = 27'd5;
        ay    = 27'd5;
        #2;
        check("rst_def", 64'(res_def), 64'd0);
        check("rst_lat4", 64'(res_lat4), 64'd0);
        check("rst_sgn", 64'(res_sgn), 64'd0);
        check("rst_trunc", 64'(res_trunc), 64'd0);
        check("rst_comb", res_comb, 64'd25);
        @(negedge clk);
        clr_n = 1'b1;

        // Table: latency-2 instances see each product after the 2nd edge
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ax = vecs[i].ax;
            ay = vecs[i].ay;
            #1;
            check($sformatf("comb_v%0d", i), res_comb, vecs[i].e_c);
            tick(1);
            if (i > 0)
                check($sformatf("def_mid_v%0d", i), 64'(res_def), 64'(vecs[i-1].e_u));
            tick(1);
            check($sformatf("def_v%0d", i), 64'(res_def), 64'(vecs[i].e_u));
            check($sformatf("sgn_v%0d", i), 64'(res_sgn), 64'(vecs[i].e_s));
            check($sformatf("trunc_v%0d", i), 64'(res_trunc), 64'(vecs[i].e_t));
        end

        // Latency-4 stream: input captured at edge i appears after edge i+3
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        clr_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ax = 27'(i);
            ay = 27'(i + 1);
            tick(1);
            if (i >= 3)
                check($sformatf("lat4_%0d", i), 64'(res_lat4), 64'((i - 3) * (i - 2)));
            else
                check($sformatf("lat4_%0d", i), 64'(res_lat4), 64'd0);
        end

        // Stage-1 stall: output keeps product of operands captured before it
        @(negedge clk);
        ax = 27'd3;
        ay = 27'd5;
        tick(2);
        check("stall_pre", 64'(res_def), 64'd15);
        @(negedge clk);
        ena = 3'b110;
        for (int i = 0; i < 3; i++) begin
            ax = 27'(7 + i);
            ay = 27'(9 + i);
            tick(1);
            check($sformatf("stall_%0d", i), 64'(res_def), 64'd15);
            @(negedge clk);
        end
        ena = 3'b111;
        ax  = 27'd7;
        ay  = 27'd9;
        tick(1);
        check("resume_1", 64'(res_def), 64'd15);
        tick(1);
        check("resume_2", 64'(res_def), 64'd63);

        // Output-stage hold, then skip straight to the newest product
        @(negedge clk);
        ena = 3'b011;
        ax  = 27'd2;
        ay  = 27'd2;
        tick(2);
        check("out_hold", 64'(res_def), 64'd63);
        @(negedge clk);
        ena = 3'b111;
        tick(1);
        check("out_skip", 64'(res_def), 64'd4);

        // Asynchronous reset between edges flushes everything in flight
        @(negedge clk);
        ax = 27'd11;
        ay = 27'd13;
        #2;
        clr_n = 1'b0;
        #1;
        check("midrst_def", 64'(res_def), 64'd0);
        check("midrst_lat4", 64'(res_lat4), 64'd0);
        check("midrst_sgn", 64'(res_sgn), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        ax = 27'd1000;
        ay = 27'd1000;
        tick(1);
        check("postrst_def_1", 64'(res_def), 64'd0);
        tick(1);
        check("postrst_def_2", 64'(res_def), 64'd1000000);
        check("postrst_lat4_2", 64'(res_lat4), 64'd0);
        tick(2);
        check("postrst_lat4_4", 64'(res_lat4), 64'd1000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
